clk_ratio_detector: RTL and testbench
=====================================

// Module: clk_ratio_detector
// PURPOSE
//  Receive-side checker for integer clock dividers.
//  - Samples a divided clock (div_in) on the fast clock and measures its period and high time in clk cycles.
//  - Reports each measurement and declares lock once the ratio is stable.
//  - Sits beside the divider outputs, on-chip or in the bench, to confirm the ratio and duty cycle (e.g. /3 = period 3, high 1).
// PARAMETERS
//  CNT_W     8  width of period/high counters and outputs
//  LOCK_CNT  4  consecutive equal periods required before locked asserts
// PORTS
//  clk         in   1      fast reference clock; all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  div_in      in   1      divided clock under measurement
//  period      out  CNT_W  last measured period in clk cycles (rise to rise)
//  high_cnt    out  CNT_W  clk cycles div_in was sampled high in that period
//  meas_valid  out  1      1-cycle pulse: period/high_cnt updated
//  locked      out  1      ratio stable for LOCK_CNT consecutive matches
//  ovf         out  1      no rising edge within 2**CNT_W-1 cycles
// BEHAVIOUR
//  Reset
//  - period, high_cnt, meas_valid, locked and ovf all clear to 0; state = IDLE.
//  - The edge-history flop (div_d) resets to 1, so a div_in already high at reset release is not seen as a rise.
//  Edge detection
//  - rise = div_s & ~div_d, where div_s is the sampled div_in.
//  State IDLE
//  - On rise: per_cnt <= 1, hi_cnt <= 1, go to MEAS.
//  - No output changes in IDLE.
//  State MEAS, non-rise cycle
//  - per_cnt <= per_cnt+1.
//  - hi_cnt <= hi_cnt + div_s.
//  State MEAS, rise cycle
//  - period <= per_cnt, high_cnt <= hi_cnt.
//  - meas_valid <= 1 on the next edge (asserted the cycle after the rise is sampled).
//  - per_cnt <= 1, hi_cnt <= 1.
//  Lock
//  - stab_cnt counts consecutive measurements equal to the previous period.
//  - First measurement after IDLE: stab_cnt = 0.
//  - Match: stab_cnt++, saturating at LOCK_CNT.
//  - Mismatch: stab_cnt <= 0, and locked drops in the same cycle as that meas_valid.
//  - locked = 1 when stab_cnt == LOCK_CNT.
//  Overflow
//  - Condition: per_cnt == 2**CNT_W-1 and no rise.
//  - Action: ovf <= 1, locked <= 0, stab_cnt <= 0, go to IDLE.
//  - period/high_cnt hold their last values.
//  - ovf is sticky; it clears with the next meas_valid or on rst.
//  Simultaneous events
//  - Rise on the saturation cycle counts as a valid measurement; no ovf.
//  - rst dominates everything.
//  - rst mid-measurement discards the partial count.
// CONFIGURATION
//  CLK_RATIO_SYNC_EN defined
//  - div_in passes through a 2-flop synchronizer (both flops reset to 1) before edge detection.
//  - All output latencies grow by 2 cycles; safe for an asynchronous div_in.
//  Undefined
//  - div_s = div_in directly; div_in must be synchronous to clk.
// STRUCTURE
//  Package clk_ratio_pkg
//  - typedef enum logic {IDLE, MEAS} cr_state_t.
//  - Default CNT_W/LOCK_CNT localparams.
//  Sub-module clk_ratio_edge_det
//  - Optional synchronizer, div_d flop, rise output.
//  Top module
//  - FSM, counters, lock/ovf logic.
// TESTING
//  1. /3 source (1 high, 2 low) -> first meas_valid after 2nd rise: period=3, high_cnt=1; locked on 5th meas_valid.
//  2. /8 50% source -> period=8, high_cnt=4; meas_valid every 8 cycles.
//  3. Locked on /3, switch to /5 (2 high) -> locked=0 with first period=5 pulse; relocks 4 pulses later.
//  4. div_in held low, CNT_W=8 -> ovf=1 and locked=0 after 255 cycles w/o rise; no meas_valid; next rises clear ovf.
//  5. div_in=1 at rst release -> no meas_valid until a real 0->1; first period measured between two genuine rises.
//  6. rst pulsed mid-period while locked -> all outputs 0 next cycle; clean re-measure follows.

Source files
------------

// File: rtl/clk_ratio_pkg.sv
// Shared types and default sizing for the clock-ratio detector.
package clk_ratio_pkg;
  typedef enum logic {IDLE, MEAS} cr_state_t;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned LOCK_CNT_DEF = 4;
endpackage

// File: rtl/clk_ratio_edge_det.sv
// Rising-edge detector for div_in; CLK_RATIO_SYNC_EN adds a 2-flop synchronizer.
module clk_ratio_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic div_s,
  output logic rise
);
  logic div_d;

`ifdef CLK_RATIO_SYNC_EN
  logic [1:0] sync;

  // Reset to 1 so a high div_in at reset release does not look like a rise.
  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[0], div_in};
  end

  assign div_s = sync[1];
`else
  assign div_s = div_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) div_d <= 1'b1;
    else     div_d <= div_s;
  end

  assign rise = div_s & ~div_d;
endmodule

// File: rtl/clk_ratio_detector.sv
// Measures period/high time of a divided clock and reports lock/overflow.
// Optional input synchronizer: define CLK_RATIO_SYNC_EN.
module clk_ratio_detector
  import clk_ratio_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             ovf
);
  localparam int unsigned     SW     = $clog2(LOCK_CNT + 1);
  localparam logic [SW-1:0]   LOCK_V = SW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  cr_state_t        state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [SW-1:0]    stab_cnt;
  logic [SW-1:0]    stab_next;
  logic             first_meas;
  logic             div_s;
  logic             rise;

  clk_ratio_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .div_in (div_in),
    .div_s  (div_s),
    .rise   (rise)
  );

  always_comb begin
    stab_next = stab_cnt;
    if (stab_cnt != LOCK_V) stab_next = stab_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      ovf        <= 1'b0;
      stab_cnt   <= '0;
      first_meas <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
            state   <= MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            period     <= per_cnt;
            high_cnt   <= hi_cnt;
            meas_valid <= 1'b1;
            ovf        <= 1'b0;
            per_cnt    <= ONE;
            hi_cnt     <= ONE;
            first_meas <= 1'b0;
            // The first period after IDLE only seeds the reference value.
            if (!first_meas && per_cnt == period) begin
              stab_cnt <= stab_next;
              locked   <= (stab_next == LOCK_V);
            end else begin
              stab_cnt <= '0;
              locked   <= 1'b0;
            end
          end else if (per_cnt == '1) begin
            ovf        <= 1'b1;
            locked     <= 1'b0;
            stab_cnt   <= '0;
            first_meas <= 1'b1;
            state      <= IDLE;
          end else begin
            per_cnt <= per_cnt + ONE;
            hi_cnt  <= hi_cnt + CNT_W'(div_s);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_ratio_detector.sv
// Scoreboard bench: timestamp-based reference model feeds expected measurements.
module tb_clk_ratio_detector;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int MAXC     = (1 << CNT_W) - 1;
`ifdef CLK_RATIO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             locked;
  logic             ovf;

  clk_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .period     (period),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .locked     (locked),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    bit lk;
    int c;
  } exp_t;

  exp_t mq[$];
  exp_t oq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: rises are timestamps of the sampled stream; a period is
  // the distance between consecutive rises, high time is the count of high
  // samples in between, lock means the last LOCK_CNT+1 periods are identical.
  bit hist[$];
  bit d_prev, started, s, r, lk;
  int cyc = 0, t0, tot = 0, tot0, p, h, last_p = 0, last_h = 0;
  int runs[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hist.delete();
      repeat (LAT) hist.push_back(1'b1);
      d_prev  = 1'b1;
      started = 1'b0;
      runs.delete();
      last_p  = 0;
      last_h  = 0;
    end else begin
      hist.push_back(div_in);
      s = hist[hist.size() - 1 - LAT];
      while (hist.size() > LAT) void'(hist.pop_front());
      r = s && !d_prev;
      d_prev = s;
      if (r) begin
        if (started) begin
          p = cyc - t0;
          h = tot - tot0;
          runs.push_back(p);
          if (runs.size() > LOCK_CNT + 1) void'(runs.pop_front());
          lk = (runs.size() == LOCK_CNT + 1);
          foreach (runs[i]) if (runs[i] != p) lk = 1'b0;
          mq.push_back('{p, h, lk, cyc});
          last_p = p;
          last_h = h;
        end
        started = 1'b1;
        t0      = cyc;
        tot0    = tot;
      end else if (started && cyc - t0 == MAXC) begin
        oq.push_back('{last_p, last_h, 1'b0, cyc});
        started = 1'b0;
        runs.delete();
      end
      tot += int'(s);
    end
  end

  bit ovf_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (meas_valid) begin
      if (mq.size() == 0) chk("spurious_meas_valid", 1, 0);
      else begin
        e = mq.pop_front();
        chk("meas_cycle", cyc, e.c);
        chk("period", period, e.p);
        chk("high_cnt", high_cnt, e.h);
        chk("locked_at_meas", locked, e.lk);
        chk("ovf_cleared_at_meas", ovf, 0);
      end
    end
    if (oq.size() > 0 && oq[0].c == cyc) begin
      e = oq.pop_front();
      chk("ovf_set", ovf, 1);
      chk("locked_after_ovf", locked, 0);
      chk("period_hold", period, e.p);
      chk("high_hold", high_cnt, e.h);
    end else if (ovf && !ovf_q) begin
      chk("spurious_ovf", 1, 0);
    end
    ovf_q = ovf;
  end

  task automatic put(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      div_in = v;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      put(1'b1, hi);
      put(1'b0, lo);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    rst = 1'b1;
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    wave(1, 2, 12);            // /3 duty 1/3
    wave(4, 4, 8);             // /8 50%
    wave(2, 3, 8);             // switch to /5, 2 high
    put(1'b0, 300);            // no rise: overflow
    wave(2, 2, 6);             // rises clear ovf
    wave(1, 254, 1);           // rise exactly at saturation: valid period 255
    wave(1, 255, 1);           // one cycle longer: overflow
    wave(3, 2, 6);

    repeat (25) begin
      int hi, lo, reps;
      hi   = $urandom_range(1, 6);
      lo   = $urandom_range(1, 6);
      reps = $urandom_range(1, 7);
      wave(hi, lo, reps);
      if ($urandom_range(0, 7) == 0) put(1'b0, $urandom_range(250, 258));
    end

    // Mid-period reset while locked.
    wave(1, 2, 10);
    put(1'b1, 1);
    put(1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0;
    wave(2, 1, 8);

    // div_in already high at reset release: not a rise.
    @(negedge clk);
    rst = 1'b1;
    div_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    put(1'b1, 10);
    wave(3, 3, 8);

    put(1'b0, 12);
    chk("pending_meas", mq.size(), 0);
    chk("pending_ovf", oq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
